alu_dp_sequencer: RTL and testbench
===================================

Name: alu_dp_sequencer

Overview:
- Multi-cycle controller that sequences the combinational ALU for ARM data-processing instructions.
- Accepts one decoded request per handshake and maps the ARM opcode onto the ALU's ALU_OP encoding.
- Drives the ALU from registered operands, captures F/NZCV, issues register write-back and owns the CPSR NZCV flags.
- Sits between the decode stage and the register file/CPSR.

Parameters:
- REG_AW, 4, register-file address width (Rd).
- DW, 32, datapath width; must match the ALU (32).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept (IDLE only).
- req_opcode  in  4  ARM DP opcode, instr[24:21].
- req_s  in  1  S bit: update flags.
- req_cond  in  4  condition field, instr[31:28]; used only with COND_CHECK_EN.
- req_rd  in  REG_AW  destination register.
- req_a  in  DW  Rn value.
- req_b  in  DW  shifted operand from the barrel shifter.
- req_shift_c  in  1  barrel-shifter carry-out.
- alu_op  out  4  to ALU ALU_OP.
- alu_a, alu_b  out  DW  to ALU A, B.
- alu_shc  out  1  to ALU Shift_Carry_Out.
- alu_cf, alu_vf  out  1  current CPSR C, V to the ALU.
- alu_f  in  DW  ALU result F.
- alu_nzcv  in  4  ALU NZCV.
- wb_en  out  1  one-cycle register write strobe.
- wb_addr  out  REG_AW  write address.
- wb_data  out  DW  write data.
- cpsr_nzcv  out  4  architectural flags.
- done  out  1  one-cycle completion pulse, also asserted for skipped instructions.

Behaviour:
- Reset values: all outputs 0; cpsr_nzcv=4'b0000; FSM in IDLE. Reset mid-operation aborts: no wb_en, no done, flags reset.
- FSM states: IDLE, EXEC, WB.
  - IDLE: req_ready=1. On req_valid, latch all req_* fields and go to EXEC.
  - EXEC: req_ready=0. alu_a, alu_b and alu_shc come from the latches; alu_op is the mapped opcode. alu_f and alu_nzcv are sampled at the end of EXEC. Go to WB.
  - WB: wb_en is asserted when the opcode writes back. NZCV is updated when req_s=1 or the opcode is a compare. done=1. Go to IDLE.
- Throughput: a request accepted at edge N gives wb_en/done high during cycle N+2; back-to-back acceptance is possible at edge N+3. Peak rate is 1 op per 3 cycles.
- Opcode map (ARM -> ALU_OP): 0000-0111 identity; 1000 TST->0000; 1001 TEQ->0001; 1010 CMP->0010; 1011 CMN->0100; 1100, 1101, 1110, 1111 identity.
- Write-back suppressed for opcodes 1000-1011. These always update flags, regardless of req_s.
- Flag update: cpsr_nzcv <= alu_nzcv registered at the end of EXEC. Flags take effect at the WB edge, so the next request's EXEC sees the new C/V.
- alu_cf and alu_vf are always driven from cpsr_nzcv[1] and cpsr_nzcv[0].
- wb_data = alu_f captured at the end of EXEC; it is held stable while wb_en is high. wb_addr = latched req_rd.
- req_valid outside IDLE is ignored (not accepted). Requesters hold it until req_ready.

Optional Feature:
- Macro COND_CHECK_EN.
- Defined:
  - In EXEC, req_cond is evaluated against cpsr_nzcv using the standard ARM table: EQ..LE, AL=1110, 1111 treated as AL.
  - On failure: WB suppresses wb_en and the flag update, but done still pulses at the same cycle.
- Undefined: req_cond is ignored and every instruction executes.

Decomposition:
- Shared package alu_pkg holds:
  - ARM opcode localparams (OP_AND..OP_MVN) and ALU_OP localparams.
  - Condition-code localparams.
  - FSM state enum.
- One sub-module: alu_op_map, a combinational ARM-opcode -> {alu_op, writes_rd, is_compare} decoder, reusable by the decoder.

Test Plan:
- ADD: A=32'h7FFFFFFF, B=1, S=1, Rd=3 -> wb_data=32'h80000000, wb_addr=3 at cycle N+2, cpsr_nzcv=4'b1001.
- CMP: A=5, B=5, S=0 -> wb_en stays 0, cpsr_nzcv=4'b0110, done pulses once.
- ADC chaining: ADDS FFFFFFFF+1 (C=1), then ADC 0+0 -> second result 1; verifies the flag forward to alu_cf.
- MOV with S=0: B=0, prior flags 4'b1010 -> wb_data=0 and flags unchanged. The req_valid asserted during EXEC is not accepted until IDLE.
- Assert rst_n=0 during EXEC of SUB -> no wb_en, no done, all outputs 0; next request executes normally.
- COND_CHECK_EN: cpsr Z=0, ADDEQ (cond 0000) -> no wb_en, flags unchanged, done at N+2. ADDNE (0001) -> executes.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ARM data-processing sequencer: opcodes, ALU ops, conditions, FSM states.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF;

  localparam logic [3:0] ALU_AND = 4'h0, ALU_EOR = 4'h1, ALU_SUB = 4'h2, ALU_ADD = 4'h4;

  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE;

  localparam logic [1:0] ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_WB = 2'd2;

  // nzcv is {N,Z,C,V}; 1111 is treated as always.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = !z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = !c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = !n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = !v;
      COND_HI: cond_pass = c && !z;
      COND_LS: cond_pass = !c || z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = !z && (n == v);
      COND_LE: cond_pass = z || (n != v);
      default: cond_pass = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_map.sv
// Combinational ARM DP opcode decoder: ALU op select, register write-back enable, compare flag.
module alu_op_map
  import alu_pkg::*;
(
  input  logic [3:0] i_opcode,
  output logic [3:0] o_alu_op,
  output logic       o_writes_rd,
  output logic       o_is_compare
);

  always_comb begin
    o_alu_op     = i_opcode;
    o_writes_rd  = 1'b1;
    o_is_compare = 1'b0;
    case (i_opcode)
      OP_TST: begin o_alu_op = ALU_AND; o_writes_rd = 1'b0; o_is_compare = 1'b1; end
      OP_TEQ: begin o_alu_op = ALU_EOR; o_writes_rd = 1'b0; o_is_compare = 1'b1; end
      OP_CMP: begin o_alu_op = ALU_SUB; o_writes_rd = 1'b0; o_is_compare = 1'b1; end
      OP_CMN: begin o_alu_op = ALU_ADD; o_writes_rd = 1'b0; o_is_compare = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_dp_sequencer.sv
// IDLE->EXEC->WB sequencer for ARM DP ops: wb_en/done two cycles after accept, req_ready only in IDLE.
// Build option COND_CHECK_EN enables condition-code gating of write-back and flag update.
module alu_dp_sequencer
  import alu_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int DW     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_opcode,
  input  logic              req_s,
  input  logic [3:0]        req_cond,
  input  logic [REG_AW-1:0] req_rd,
  input  logic [DW-1:0]     req_a,
  input  logic [DW-1:0]     req_b,
  input  logic              req_shift_c,
  output logic [3:0]        alu_op,
  output logic [DW-1:0]     alu_a,
  output logic [DW-1:0]     alu_b,
  output logic              alu_shc,
  output logic              alu_cf,
  output logic              alu_vf,
  input  logic [DW-1:0]     alu_f,
  input  logic [3:0]        alu_nzcv,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DW-1:0]     wb_data,
  output logic [3:0]        cpsr_nzcv,
  output logic              done
);

  logic [1:0]        r_state;
  logic              r_rdy;
  logic [3:0]        r_opcode;
  logic              r_s;
  logic [REG_AW-1:0] r_rd;
  logic [DW-1:0]     r_a;
  logic [DW-1:0]     r_b;
  logic              r_shc;
  logic              r_wb_en;
  logic [DW-1:0]     r_wb_data;
  logic              r_done;
  logic [3:0]        r_nzcv;
  logic [3:0]        w_alu_op;
  logic              w_writes_rd;
  logic              w_is_compare;
  logic              w_cond_ok;

  alu_op_map u_op_map (
    .i_opcode     (r_opcode),
    .o_alu_op     (w_alu_op),
    .o_writes_rd  (w_writes_rd),
    .o_is_compare (w_is_compare)
  );

`ifdef COND_CHECK_EN
  logic [3:0] r_cond;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  r_cond <= 4'h0;
    else if (r_state == ST_IDLE && r_rdy && req_valid) r_cond <= req_cond;
  end

  assign w_cond_ok = cond_pass(r_cond, r_nzcv);
`else
  logic w_unused_cond;
  assign w_unused_cond = ^req_cond;
  assign w_cond_ok     = 1'b1;
`endif

  // r_rdy is registered so req_ready reads 0 while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_rdy     <= 1'b0;
      r_opcode  <= '0;
      r_s       <= 1'b0;
      r_rd      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_shc     <= 1'b0;
      r_wb_en   <= 1'b0;
      r_wb_data <= '0;
      r_done    <= 1'b0;
      r_nzcv    <= 4'b0000;
    end else begin
      r_wb_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_rdy <= 1'b1;
          if (r_rdy && req_valid) begin
            r_opcode <= req_opcode;
            r_s      <= req_s;
            r_rd     <= req_rd;
            r_a      <= req_a;
            r_b      <= req_b;
            r_shc    <= req_shift_c;
            r_rdy    <= 1'b0;
            r_state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_wb_data <= alu_f;
          r_wb_en   <= w_cond_ok && w_writes_rd;
          r_done    <= 1'b1;
          if (w_cond_ok && (r_s || w_is_compare)) r_nzcv <= alu_nzcv;
          r_state   <= ST_WB;
        end
        ST_WB: begin
          r_rdy   <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = r_rdy;
  assign alu_op    = w_alu_op;
  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_shc   = r_shc;
  assign alu_cf    = r_nzcv[1];
  assign alu_vf    = r_nzcv[0];
  assign wb_en     = r_wb_en;
  assign wb_addr   = r_rd;
  assign wb_data   = r_wb_data;
  assign cpsr_nzcv = r_nzcv;
  assign done      = r_done;

endmodule

// File: tb/tb_alu_dp_sequencer.sv
// Self-checking bench for alu_dp_sequencer with a behavioural ARM ALU stand-in.
module tb_alu_dp_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_opcode;
  logic        req_s;
  logic [3:0]  req_cond;
  logic [3:0]  req_rd;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_shift_c;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_shc;
  logic        alu_cf;
  logic        alu_vf;
  logic [31:0] alu_f;
  logic [3:0]  alu_nzcv;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic [3:0]  cpsr_nzcv;
  logic        done;

  int total = 0;
  int bad   = 0;
  logic [3:0] m_nzcv = 4'b0000;

  always #5 clk = ~clk;

  alu_dp_sequencer #(.REG_AW(4), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_s(req_s), .req_cond(req_cond), .req_rd(req_rd),
    .req_a(req_a), .req_b(req_b), .req_shift_c(req_shift_c),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_shc(alu_shc),
    .alu_cf(alu_cf), .alu_vf(alu_vf), .alu_f(alu_f), .alu_nzcv(alu_nzcv),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .cpsr_nzcv(cpsr_nzcv), .done(done)
  );

  // ARM DP semantics; returns {N,Z,C,V,F}. The stand-in ALU only knows 12 ops (cmp_ok=0).
  function automatic logic [35:0] alu_fn(input logic [3:0] op_in, input logic [31:0] a, input logic [31:0] b,
                                         input logic shc, input logic cf, input logic vf, input logic cmp_ok);
    logic [32:0] t;
    logic [31:0] f, x, y;
    logic [3:0]  op;
    logic        cin, ar, c, v;
    op = op_in;
    if (op_in inside {4'h8, 4'h9, 4'hA, 4'hB}) begin
      if (!cmp_ok) return {4'b0000, 32'hDEADBEEF};
      case (op_in)
        4'h8:    op = 4'h0;
        4'h9:    op = 4'h1;
        4'hA:    op = 4'h2;
        default: op = 4'h4;
      endcase
    end
    f = '0; x = a; y = b; cin = 1'b0; ar = 1'b1; c = shc; v = vf;
    case (op)
      4'h0: begin f = a & b; ar = 1'b0; end
      4'h1: begin f = a ^ b; ar = 1'b0; end
      4'h2: begin y = ~b; cin = 1'b1; end
      4'h3: begin x = b; y = ~a; cin = 1'b1; end
      4'h5: cin = cf;
      4'h6: begin y = ~b; cin = cf; end
      4'h7: begin x = b; y = ~a; cin = cf; end
      4'hC: begin f = a | b; ar = 1'b0; end
      4'hD: begin f = b; ar = 1'b0; end
      4'hE: begin f = a & ~b; ar = 1'b0; end
      4'hF: begin f = ~b; ar = 1'b0; end
      default: ;
    endcase
    if (ar) begin
      t = {1'b0, x} + {1'b0, y} + {32'b0, cin};
      f = t[31:0];
      c = t[32];
      v = (x[31] == y[31]) && (f[31] != x[31]);
    end
    return {f[31], f == 32'h0, c, v, f};
  endfunction

  function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] fl);
    logic n, z, c, v;
    {n, z, c, v} = fl;
    case (cc)
      4'h0: return z;            4'h1: return !z;
      4'h2: return c;            4'h3: return !c;
      4'h4: return n;            4'h5: return !n;
      4'h6: return v;            4'h7: return !v;
      4'h8: return c && !z;      4'h9: return !c || z;
      4'hA: return n == v;       4'hB: return n != v;
      4'hC: return !z && n == v; 4'hD: return z || n != v;
      default: return 1'b1;
    endcase
  endfunction

  logic [35:0] alu_res;
  always_comb alu_res = alu_fn(alu_op, alu_a, alu_b, alu_shc, alu_cf, alu_vf, 1'b0);
  assign alu_f    = alu_res[31:0];
  assign alu_nzcv = alu_res[35:32];

  typedef struct {
    logic [3:0]  op;
    logic        s;
    logic [3:0]  cond;
    logic [3:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic        shc;
    logic [3:0]  e_aop;
    logic        e_wb;
    logic [31:0] e_data;
    logic [3:0]  e_nzcv;
  } vec_t;

  function automatic vec_t mk(logic [3:0] op, logic s, logic [3:0] rd, logic [31:0] a, logic [31:0] b,
                              logic shc, logic [3:0] aop, logic wb, logic [31:0] d, logic [3:0] nz);
    vec_t v;
    v.op = op; v.s = s; v.cond = 4'hE; v.rd = rd; v.a = a; v.b = b; v.shc = shc;
    v.e_aop = aop; v.e_wb = wb; v.e_data = d; v.e_nzcv = nz;
    return v;
  endfunction

  // Expected outcome of a request from the architectural rules and the model flags.
  function automatic vec_t predict(vec_t r, logic [3:0] fl);
    vec_t v;
    logic [35:0] res;
    logic cmp, ok;
    v = r;
    res = alu_fn(r.op, r.a, r.b, r.shc, fl[1], fl[0], 1'b1);
    cmp = (r.op >= 4'h8) && (r.op <= 4'hB);
`ifdef COND_CHECK_EN
    ok = cond_ok(r.cond, fl);
`else
    ok = 1'b1;
`endif
    case (r.op)
      4'h8: v.e_aop = 4'h0;
      4'h9: v.e_aop = 4'h1;
      4'hA: v.e_aop = 4'h2;
      4'hB: v.e_aop = 4'h4;
      default: v.e_aop = r.op;
    endcase
    v.e_wb   = ok && !cmp;
    v.e_data = res[31:0];
    v.e_nzcv = (ok && (r.s || cmp)) ? res[35:32] : fl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic scramble();
    req_valid = 1'b1; req_opcode = 4'($urandom); req_s = 1'($urandom); req_cond = 4'($urandom);
    req_rd = 4'($urandom); req_a = $urandom; req_b = $urandom; req_shift_c = 1'($urandom);
  endtask

  // Called at a negedge; returns at the negedge of the IDLE cycle after WB.
  task automatic send(input vec_t v);
    int n;
    req_valid = 1'b1; req_opcode = v.op; req_s = v.s; req_cond = v.cond; req_rd = v.rd;
    req_a = v.a; req_b = v.b; req_shift_c = v.shc;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("accept_wait", 36'(n < 20), 36'd1);
    if (n >= 20) begin req_valid = 1'b0; return; end
    @(negedge clk);
    scramble();
    chk("exec_ready", 36'(req_ready), 36'd0);
    chk("exec_pulses", {34'd0, wb_en, done}, 36'd0);
    chk("exec_alu_op", 36'(alu_op), 36'(v.e_aop));
    chk("exec_alu_a", 36'(alu_a), 36'(v.a));
    chk("exec_alu_b", 36'(alu_b), 36'(v.b));
    chk("exec_shc_cv", {33'd0, alu_shc, alu_cf, alu_vf}, {33'd0, v.shc, m_nzcv[1:0]});
    @(negedge clk);
    scramble();
    chk("wb_ready", 36'(req_ready), 36'd0);
    chk("wb_done", 36'(done), 36'd1);
    chk("wb_en", 36'(wb_en), 36'(v.e_wb));
    if (v.e_wb) chk("wb_data", 36'(wb_data), 36'(v.e_data));
    chk("wb_addr", 36'(wb_addr), 36'(v.rd));
    chk("cpsr", 36'(cpsr_nzcv), 36'(v.e_nzcv));
    m_nzcv = v.e_nzcv;
    @(negedge clk);
    scramble();
    chk("idle_ready", 36'(req_ready), 36'd1);
    chk("idle_pulses", {34'd0, wb_en, done}, 36'd0);
  endtask

  vec_t tbl[12];

  initial begin
    vec_t v;
    int spur;
    rst_n = 1'b0; req_valid = 1'b0; req_opcode = '0; req_s = 1'b0; req_cond = '0;
    req_rd = '0; req_a = '0; req_b = '0; req_shift_c = 1'b0;

    tbl[0]  = mk(4'h4, 1, 4'd3,  32'h7FFFFFFF, 32'h1,        0, 4'h4, 1, 32'h80000000, 4'b1001);
    tbl[1]  = mk(4'hA, 0, 4'd7,  32'h5,        32'h5,        0, 4'h2, 0, 32'h0,        4'b0110);
    tbl[2]  = mk(4'h4, 1, 4'd1,  32'hFFFFFFFF, 32'h1,        0, 4'h4, 1, 32'h0,        4'b0110);
    tbl[3]  = mk(4'h5, 0, 4'd2,  32'h0,        32'h0,        0, 4'h5, 1, 32'h1,        4'b0110);
    tbl[4]  = mk(4'h9, 0, 4'd4,  32'h80000000, 32'h0,        0, 4'h1, 0, 32'h0,        4'b1000);
    tbl[5]  = mk(4'hB, 0, 4'd5,  32'h80000000, 32'h80000000, 1, 4'h4, 0, 32'h0,        4'b0111);
    tbl[6]  = mk(4'hA, 0, 4'd6,  32'hFFFFFFFF, 32'h1,        0, 4'h2, 0, 32'h0,        4'b1010);
    tbl[7]  = mk(4'hD, 0, 4'd9,  32'h12345678, 32'h0,        1, 4'hD, 1, 32'h0,        4'b1010);
    tbl[8]  = mk(4'hF, 1, 4'd15, 32'h0,        32'h0,        0, 4'hF, 1, 32'hFFFFFFFF, 4'b1000);
    tbl[9]  = mk(4'h6, 1, 4'd6,  32'h5,        32'h3,        0, 4'h6, 1, 32'h1,        4'b0010);
    tbl[10] = mk(4'h3, 1, 4'd8,  32'h3,        32'hA,        0, 4'h3, 1, 32'h7,        4'b0010);
    tbl[11] = mk(4'hE, 0, 4'd10, 32'hFF,       32'h0F,       1, 4'hE, 1, 32'hF0,       4'b0010);

    repeat (3) @(negedge clk);
    chk("rst_ctrl", {32'd0, req_ready, wb_en, done, alu_shc}, 36'd0);
    chk("rst_flags", {28'd0, cpsr_nzcv, alu_cf, alu_vf, 2'b00}, 36'd0);
    chk("rst_alu", {28'd0, alu_op, 4'h0} | 36'(alu_a) | 36'(alu_b), 36'd0);
    chk("rst_wb", 36'(wb_data) | 36'(wb_addr), 36'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) send(tbl[i]);

`ifdef COND_CHECK_EN
    v = mk(4'h4, 1, 4'd5, 32'h1, 32'h1, 0, 4'h4, 0, 32'h2, 4'b0010);
    v.cond = 4'h0;
    send(v);
    v = mk(4'h4, 1, 4'd5, 32'h1, 32'h1, 0, 4'h4, 1, 32'h2, 4'b0000);
    v.cond = 4'h1;
    send(v);
`endif

    for (int i = 0; i < 40; i++) begin
      v.op = 4'($urandom); v.s = 1'($urandom); v.cond = 4'($urandom); v.rd = 4'($urandom);
      v.shc = 1'($urandom);
      v.a = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF << $urandom_range(0, 1) : $urandom;
      v.b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1)) - 32'd1 : $urandom;
      send(predict(v, m_nzcv));
    end

    // Reset while a SUBS is in EXEC must leave no trace.
    req_valid = 1'b1; req_opcode = 4'h2; req_s = 1'b1; req_cond = 4'hE; req_rd = 4'd11;
    req_a = 32'h9; req_b = 32'h4; req_shift_c = 1'b0;
    spur = 0;
    while (!req_ready && spur < 20) begin @(negedge clk); spur++; end
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", {33'd0, req_ready, wb_en, done}, 36'd0);
    chk("midrst_regs", 36'(alu_a) | 36'(alu_b) | 36'(wb_data) | {28'd0, cpsr_nzcv, alu_op}, 36'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_nzcv = 4'b0000;
    spur = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (wb_en || done) spur++;
    end
    chk("midrst_no_pulse", 36'(spur), 36'd0);
    send(mk(4'h4, 1, 4'd4, 32'h2, 32'h3, 0, 4'h4, 1, 32'h5, 4'b0000));
    req_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
